// File: rtl/component_register_bank_if.sv
// rtl/component_register_bank_if.sv - request/response port bundle for component_register_bank
interface component_register_bank_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int REG_WIDTH  = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0]  req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [REG_WIDTH-1:0]  rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/component_register_bank.sv
// rtl/component_register_bank.sv - masked register bank with read-only version word 0
// Optional access counter at address N_REGS: COMPONENT_REGISTER_BANK_ACCESS_COUNT_EN
module component_register_bank #(
    parameter int                          N_REGS      = 4,
    parameter int                          REG_WIDTH   = 32,
    parameter int                          ADDR_WIDTH  = 4,
    parameter logic [31:0]                 VERSION     = 32'h0001_1_01_0,
    parameter logic [N_REGS*REG_WIDTH-1:0] READ_MASK   = {N_REGS*REG_WIDTH{1'b1}},
    parameter logic [N_REGS*REG_WIDTH-1:0] WRITE_MASK  = {N_REGS*REG_WIDTH{1'b1}},
    parameter logic [N_REGS*REG_WIDTH-1:0] RESET_VALUE = {N_REGS*REG_WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    component_register_bank_if.slave      bus,
    input  logic [N_REGS*REG_WIDTH-1:0]   hw_in,
    output logic [N_REGS*REG_WIDTH-1:0]   reg_q
);
    localparam int W = REG_WIDTH;

    typedef enum logic {IDLE, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   stored [1:N_REGS-1];
    logic [31:0]    addr_ext;
    logic           accept;
    logic           in_range;
    logic           is_count;
    logic [W-1:0]   rd_word;
    logic [W-1:0]   count_rdata;
    logic [W-1:0]   rdata_d;
    logic           err_d;
    logic           unused_hw0;

    // Word 0 is a constant; its hardware inputs are deliberately ignored.
    assign unused_hw0 = ^hw_in[W-1:0];
    assign addr_ext   = 32'(bus.req_addr);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg_q[0 +: W] = W'(VERSION);
    for (genvar g = 1; g < N_REGS; g++) begin : g_word
        localparam logic [W-1:0] WM = WRITE_MASK[g*W +: W];
        assign reg_q[g*W +: W] = (stored[g] & WM) | (hw_in[g*W +: W] & ~WM);
    end

    always_comb begin
        rd_word  = '0;
        in_range = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (addr_ext == 32'(i)) begin
                rd_word  = reg_q[i*W +: W] & READ_MASK[i*W +: W];
                in_range = 1'b1;
            end
        end
    end

`ifdef COMPONENT_REGISTER_BANK_ACCESS_COUNT_EN
    logic [31:0] access_count;

    assign is_count    = (addr_ext == 32'(N_REGS));
    assign count_rdata = W'(access_count);

    // Saturating count of every accepted request; a read of it returns the pre-increment value.
    always_ff @(posedge clk) begin
        if (rst)                              access_count <= '0;
        else if (accept && access_count != '1) access_count <= access_count + 32'd1;
    end
`else
    assign is_count    = 1'b0;
    assign count_rdata = '0;
`endif

    always_comb begin
        err_d   = !in_range && !is_count;
        rdata_d = '0;
        if (!bus.req_write && !err_d) rdata_d = is_count ? count_rdata : rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < N_REGS; i++) stored[i] <= RESET_VALUE[i*W +: W];
        end else if (accept && bus.req_write) begin
            for (int i = 1; i < N_REGS; i++) begin
                if (addr_ext == 32'(i))
                    stored[i] <= (stored[i] & ~WRITE_MASK[i*W +: W]) |
                                 (bus.req_wdata & WRITE_MASK[i*W +: W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (accept) begin
            bus.rsp_rdata <= rdata_d;
            bus.rsp_err   <= err_d;
        end
    end
endmodule

// File: tb/tb_component_register_bank.sv
// tb/tb_component_register_bank.sv - scoreboard bench for component_register_bank
module tb_component_register_bank;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam logic [N*W-1:0] RMASK = {32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [N*W-1:0] WMASK = {32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] hw_in;
    logic [N*W-1:0] reg_q;
    exp_t           exp_q[$];
    exp_t           mon_e;
    int             errors = 0;
    int             checks = 0;
    int             acc = 0;

    component_register_bank_if #(.ADDR_WIDTH(AW), .REG_WIDTH(W)) bif ();

    component_register_bank #(
        .N_REGS(N), .REG_WIDTH(W), .ADDR_WIDTH(AW),
        .READ_MASK(RMASK), .WRITE_MASK(WMASK), .RESET_VALUE('0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bif.slave), .hw_in(hw_in), .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bif.rsp_valid && bif.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h with no expected entry", bif.rsp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({mon_e.name, "_rdata"}, bif.rsp_rdata, mon_e.rdata);
                    chk({mon_e.name, "_err"}, 32'(bif.rsp_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic issue_accept(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                                input string name, input logic [31:0] er, input logic ee);
        exp_t t;
        int   n = 0;
        @(posedge clk); #1;
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = a;
        bif.req_wdata = d;
        t.name  = name;
        t.rdata = er;
        t.err   = ee;
        exp_q.push_back(t);
        while (!bif.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got req_ready low for %0d cycles expected high", name, n);
        end
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        acc++;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (!(bif.rsp_valid && bif.rsp_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp: got no response in %0d cycles expected one", name, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input string name, input logic [31:0] er, input logic ee);
        issue_accept(wr, a, d, name, er, ee);
        wait_rsp(name);
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.rsp_ready = 1'b1;
        hw_in = {32'h0000_0000, 32'h5678_1234, 32'h0000_0000, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bif.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
        chk("rst_regq_w0", reg_q[0 +: 32], 32'h0001_1010);
        chk("rst_regq_w1", reg_q[32 +: 32], 32'd0);
        chk("rst_regq_w2", reg_q[64 +: 32], 32'h0000_1234);
        chk("rst_regq_w3", reg_q[96 +: 32], 32'd0);
        rst = 1'b0;

        xfer(1'b0, 4'd0, 32'd0, "rd_version", 32'h0001_1010, 1'b0);

        issue_accept(1'b1, 4'd1, 32'hDEAD_BEEF, "wr_w1", 32'd0, 1'b0);
        chk("regq_w1_after_wr", reg_q[32 +: 32], 32'hDEAD_BEEF);
        wait_rsp("wr_w1");
        xfer(1'b0, 4'd1, 32'd0, "rd_w1", 32'hDEAD_BEEF, 1'b0);

        xfer(1'b1, 4'd2, 32'hFFFF_FFFF, "wr_w2", 32'd0, 1'b0);
        xfer(1'b0, 4'd2, 32'd0, "rd_w2", 32'hFFFF_1234, 1'b0);
        chk("regq_w2", reg_q[64 +: 32], 32'hFFFF_1234);
        hw_in[64 +: 32] = 32'h5678_00C3;
        #1;
        chk("regq_w2_hw_mirror", reg_q[64 +: 32], 32'hFFFF_00C3);
        xfer(1'b0, 4'd2, 32'd0, "rd_w2_hw", 32'hFFFF_00C3, 1'b0);

        xfer(1'b1, 4'd3, 32'hA5A5_A5A5, "wr_w3", 32'd0, 1'b0);
        xfer(1'b0, 4'd3, 32'd0, "rd_w3_masked", 32'h0000_00A5, 1'b0);
        chk("regq_w3_full", reg_q[96 +: 32], 32'hA5A5_A5A5);

        xfer(1'b1, 4'd0, 32'h1234_5678, "wr_version", 32'd0, 1'b0);
        xfer(1'b0, 4'd0, 32'd0, "rd_version_again", 32'h0001_1010, 1'b0);

        bif.rsp_ready = 1'b0;
        issue_accept(1'b0, 4'd7, 32'd0, "rd_oor7", 32'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("hold_rsp_valid", 32'(bif.rsp_valid), 32'd1);
            chk("hold_rsp_err", 32'(bif.rsp_err), 32'd1);
            chk("hold_rsp_rdata", bif.rsp_rdata, 32'd0);
            chk("hold_req_ready", 32'(bif.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bif.rsp_ready = 1'b1;
        wait_rsp("rd_oor7");

        xfer(1'b1, 4'd5, 32'h1111_1111, "wr_oor5", 32'd0, 1'b1);
        xfer(1'b0, 4'd1, 32'd0, "rd_w1_nowrap", 32'hDEAD_BEEF, 1'b0);
        xfer(1'b0, 4'd15, 32'd0, "rd_oor15", 32'd0, 1'b1);

`ifdef COMPONENT_REGISTER_BANK_ACCESS_COUNT_EN
        xfer(1'b0, 4'd4, 32'd0, "rd_count", 32'(acc), 1'b0);
        xfer(1'b1, 4'd4, 32'hFFFF_FFFF, "wr_count", 32'd0, 1'b0);
        xfer(1'b0, 4'd4, 32'd0, "rd_count2", 32'(acc), 1'b0);
`else
        xfer(1'b0, 4'd4, 32'd0, "rd_addr_nregs", 32'd0, 1'b1);
`endif

        bif.rsp_ready = 1'b0;
        issue_accept(1'b0, 4'd1, 32'd0, "rd_dropped", 32'hDEAD_BEEF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bif.req_ready), 32'd1);
        chk("midrst_rsp_err", 32'(bif.rsp_err), 32'd0);
        chk("midrst_regq_w1", reg_q[32 +: 32], 32'd0);
        rst = 1'b0;
        exp_q.delete();
        acc = 0;
        bif.rsp_ready = 1'b1;

        xfer(1'b0, 4'd1, 32'd0, "rd_w1_post_rst", 32'd0, 1'b0);
`ifdef COMPONENT_REGISTER_BANK_ACCESS_COUNT_EN
        xfer(1'b0, 4'd4, 32'd0, "rd_count_post_rst", 32'(acc), 1'b0);
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
